// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM states, BCD digit
// type, per-digit maxima and the active-low anode pattern for each scan slot.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_UNITS_MAX = 4'd9;
    localparam bcd_t SEC_TENS_MAX  = 4'd5;
    localparam bcd_t MIN_UNITS_MAX = 4'd9;
    localparam bcd_t MIN_TENS_MAX  = 4'd5;

    localparam logic [3:0] ANODE_SEC_UNITS = 4'b1110;
    localparam logic [3:0] ANODE_SEC_TENS  = 4'b1101;
    localparam logic [3:0] ANODE_MIN_UNITS = 4'b1011;
    localparam logic [3:0] ANODE_MIN_TENS  = 4'b0111;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = ANODE_SEC_UNITS;
            2'd1:    a = ANODE_SEC_TENS;
            2'd2:    a = ANODE_MIN_UNITS;
            2'd3:    a = ANODE_MIN_TENS;
            default: a = ANODE_SEC_UNITS;
        endcase
        return a;
    endfunction

    // Anything at or beyond the maximum rolls to zero, so a corrupted digit self-heals.
    function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max);
        bcd_t n;
        if (d >= max) begin
            n = 4'd0;
        end else begin
            n = d + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time cascade: counts 0..MAX when enabled, carries out
// combinationally on the wrapping step so the whole chain moves on one edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output bcd_t digit_o,
    output logic carry_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = 4'd0;
        end else if (en_i) begin
            digit_d = bcd_next(digit_q, MAX);
        end else begin
            digit_d = digit_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign carry_o = en_i & (digit_q >= MAX);
    assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch: start/stop/clear FSM, seconds prescaler, four-digit BCD
// cascade and a free-running scanner driving one shared bindata bus plus anodes.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic [3:0]  bindata,
    output logic [3:0]  anode,
    output logic        running,
    output logic [15:0] digits
);

    localparam int unsigned PW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = (REFRESH_DIV > 32'd1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 32'd1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 32'd1);

    sw_state_e     state_q;
    sw_state_e     state_d;
    logic          running_q;
    logic          running_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_s;
    logic [RW-1:0] refresh_q;
    logic [RW-1:0] refresh_d;
    logic [1:0]    scan_idx_q;
    logic [1:0]    scan_idx_d;
    logic [3:0]    bindata_q;
    logic [3:0]    bindata_d;
    logic [3:0]    anode_q;
    logic [3:0]    anode_d;

    bcd_t sec_units_s;
    bcd_t sec_tens_s;
    bcd_t min_units_s;
    bcd_t min_tens_s;
    logic carry_su_s;
    logic carry_st_s;
    logic carry_mu_s;
    logic unused_wrap_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
        end
    end

    // clear outranks start_stop when both arrive on the same cycle.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    always_comb begin
        running_d = 1'b0;
        if (state_d == RUN) begin
            running_d = 1'b1;
        end else begin
            running_d = 1'b0;
        end
    end

    // Prescaler holds its fraction through PAUSE so a resumed second finishes on time.
    always_comb begin
        presc_d = presc_q;
        tick_s  = 1'b0;
        if (clear) begin
            presc_d = {PW{1'b0}};
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = {PW{1'b0}};
                tick_s  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1'b1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= {PW{1'b0}};
        end else begin
            presc_q <= presc_d;
        end
    end

    bcd_digit_counter #(.MAX(SEC_UNITS_MAX)) u_sec_units (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clear),
        .en_i    (tick_s),
        .digit_o (sec_units_s),
        .carry_o (carry_su_s)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clear),
        .en_i    (carry_su_s),
        .digit_o (sec_tens_s),
        .carry_o (carry_st_s)
    );

    bcd_digit_counter #(.MAX(MIN_UNITS_MAX)) u_min_units (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clear),
        .en_i    (carry_st_s),
        .digit_o (min_units_s),
        .carry_o (carry_mu_s)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clear),
        .en_i    (carry_mu_s),
        .digit_o (min_tens_s),
        .carry_o (unused_wrap_s)
    );

    // Scanner runs in every state; bindata and anode are loaded from the same index.
    always_comb begin
        refresh_d  = refresh_q;
        scan_idx_d = scan_idx_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d  = {RW{1'b0}};
            scan_idx_d = scan_idx_q + 2'd1;
        end else begin
            refresh_d  = refresh_q + RW'(1'b1);
            scan_idx_d = scan_idx_q;
        end
    end

    always_comb begin
        bindata_d = 4'd0;
        case (scan_idx_q)
            2'd0:    bindata_d = sec_units_s;
            2'd1:    bindata_d = sec_tens_s;
            2'd2:    bindata_d = min_units_s;
            2'd3:    bindata_d = min_tens_s;
            default: bindata_d = sec_units_s;
        endcase
        anode_d = anode_for(scan_idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q  <= {RW{1'b0}};
            scan_idx_q <= 2'd0;
            bindata_q  <= 4'd0;
            anode_q    <= ANODE_SEC_UNITS;
        end else begin
            refresh_q  <= refresh_d;
            scan_idx_q <= scan_idx_d;
            bindata_q  <= bindata_d;
            anode_q    <= anode_d;
        end
    end

    assign running = running_q;
    assign bindata = bindata_q;
    assign anode   = anode_q;
    assign digits  = {min_tens_s, min_units_s, sec_tens_s, sec_units_s};

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- MM:SS stopwatch timebase and display scanner that sits directly upstream of the BCD-to-7-segment decoder.
- Divides the system clock into a seconds tick and keeps four BCD digits (minutes tens/units, seconds tens/units).
- Runs a start/stop/clear control FSM.
- Time-multiplexes the digits onto a single 4-bit bindata bus with matching active-low anode enables for a 4-digit common-anode display.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per count tick (1 s at 100 MHz); legal range >= 2.
- REFRESH_DIV, 100_000: clk cycles per digit-scan step (1 kHz scan at 100 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_stop  input  1  single-cycle pulse, already synchronised and debounced; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes time and returns to IDLE.
- bindata  output  4  BCD value of the currently scanned digit, to the decoder.
- anode  output  4  active-low digit enable, one-hot-low; bit0 = seconds units ... bit3 = minutes tens.
- running  output  1  high while the FSM is in RUN.
- digits  output  16  {min_tens, min_units, sec_tens, sec_units}, each 4-bit BCD.

Behaviour:
- Reset values (applied asynchronously on rst high):
  - state=IDLE, all digits=0, prescaler=0, refresh counter=0, scan index=0.
  - bindata=4'd0, anode=4'b1110, running=0.
- FSM states and transitions:
  - IDLE -(start_stop)-> RUN.
  - RUN -(start_stop)-> PAUSE.
  - PAUSE -(start_stop)-> RUN.
  - clear from any state -> IDLE: digits=0, prescaler=0.
  - clear and start_stop on the same cycle: clear wins, state=IDLE.
- running is registered and equals (state==RUN).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - In RUN, at prescaler==TICK_DIV-1 the same edge sets prescaler=0 and increments the time by one second.
  - Held (not cleared) in PAUSE, so a resumed second completes its remaining fraction.
  - After a start from IDLE, the first increment lands TICK_DIV cycles after the edge that entered RUN.
- Time increment, BCD cascade:
  - sec_units 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_units.
  - min_units 9->0 carries into min_tens.
  - min_tens 5->0.
  - 59:59 wraps to 00:00 and counting continues in RUN.
  - Digits never hold a value outside their legal range (sec_tens/min_tens 0-5, others 0-9).
- Scanner:
  - Free-running in every state, including IDLE and PAUSE.
  - Refresh counter counts 0..REFRESH_DIV-1; at terminal count the scan index increments mod 4 (3->0).
  - bindata and anode are registered together from the scan index on the same edge, so they are never misaligned.
  - index0: anode=1110, bindata=sec_units; index1: 1101, sec_tens; index2: 1011, min_units; index3: 0111, min_tens.
  - bindata reflects digit values as of the previous cycle (one-cycle display latency relative to digits).
- digits output is the live counter register, no added latency.
- Reset mid-count or mid-scan: immediate return to the reset values; no partial carry is retained.
- Counter widths: prescaler is $clog2(TICK_DIV) bits and the refresh counter is $clog2(REFRESH_DIV) bits; no overflow past terminal count.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE}.
  - BCD digit type (4-bit).
  - Localparams SEC_UNITS_MAX=9, SEC_TENS_MAX=5, MIN_UNITS_MAX=9, MIN_TENS_MAX=5.
  - Anode one-hot-low constant table.
- One natural sub-module: bcd_digit_counter, a single BCD digit with enable, clear, parameterised max and carry-out. It is instantiated four times in a carry chain.
- The scanner stays inline.

Test Plan:
- Run with TICK_DIV=4, REFRESH_DIV=2, rst pulsed for 3 cycles, start_stop pulsed once -> running=1 next edge; digits=16'h0001 exactly 4 cycles after entering RUN; 16'h0002 after 8 cycles.
- Load time near the wrap by running 3599 ticks -> digits=16'h5959; one more tick -> 16'h0000 with running still 1.
- Check the 09->10 and 59->100 carries -> digits go 16'h0009->16'h0010, and 16'h0059->16'h0100.
- Pause/resume: start, wait 2 cycles, start_stop (PAUSE), wait 20 cycles, start_stop (RUN) -> digits stay 16'h0000 throughout the pause; first increment arrives 2 cycles after resume (prescaler held).
- Simultaneous clear and start_stop while RUN at 16'h0123 -> state=IDLE, running=0, digits=16'h0000 next edge; a later start_stop restarts from zero.
- Scanner with digits=16'h1234 in PAUSE -> anode/bindata sequence (1110,4),(1101,3),(1011,2),(0111,1) repeating every 2 cycles per digit.
- Async rst mid-sequence -> anode=1110, bindata=0, digits=0 without waiting for a clock edge.
